// File: rtl/lcd_pkg.sv
// -----------------------------------------------------------------------------
// lcd_pkg
//   Shared definitions for the LCD line-buffer slice.
//   - Default line geometry (active pixels per line, bank address width)
//   - Write-side FSM state encoding
//   - RGB565 -> RGB888 expansion helper (MSB replication into the low bits so
//     that full-scale 5/6-bit values map to 0xFF and zero stays zero)
// -----------------------------------------------------------------------------
package lcd_pkg;

    localparam int H_ACTIVE_DEF = 480;
    localparam int ADDR_W_DEF   = 9;
    localparam int PIX_W        = 16;

    typedef enum logic {
        W_WAIT_SOF = 1'b0,
        W_FILL     = 1'b1
    } wr_state_t;

    typedef struct packed {
        logic [7:0] red;
        logic [7:0] green;
        logic [7:0] blue;
    } rgb888_t;

    // pix = {r[4:0], g[5:0], b[4:0]}
    function automatic rgb888_t rgb565_to_888(input logic [PIX_W-1:0] pix);
        rgb888_t o;
        o.red   = {pix[15:11], pix[15:13]};
        o.green = {pix[10:5],  pix[10:9]};
        o.blue  = {pix[4:0],   pix[4:2]};
        return o;
    endfunction

endpackage

// File: rtl/lcd_line_ram.sv
// -----------------------------------------------------------------------------
// lcd_line_ram
//   Simple dual-port RAM holding both line banks (bank select is the address
//   MSB). One write port, one synchronous-read port; the read data register
//   holds its value whenever re is low. Written in the plain single-clock
//   style that maps onto a Gowin BSRAM in SDP mode.
//
// Ports
//   clk    in   clock
//   we     in   write enable
//   waddr  in   write address {bank, pixel}
//   wdata  in   write data (RGB565)
//   re     in   read enable
//   raddr  in   read address {bank, pixel}
//   rdata  out  registered read data, valid the cycle after re
// -----------------------------------------------------------------------------
module lcd_line_ram
    import lcd_pkg::*;
#(
    parameter int DATA_W = PIX_W,
    parameter int ADDR_W = ADDR_W_DEF + 1
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:(1 << ADDR_W) - 1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/lcd_line_buffer.sv
// -----------------------------------------------------------------------------
// lcd_line_buffer
//   Ping-pong line buffer between an RGB565 pixel producer and the LCD RGB
//   timing generator. The writer fills one bank per line from a valid/ready
//   stream; the reader plays a full bank out on the timing generator's pixel
//   strobe as RGB888. Underruns (line start with no data) and frame-sync
//   errors (s_sof mid-line) are reported as sticky flags.
//
// Ports
//   clk        in   system clock
//   rst_n      in   synchronous active-low reset
//   s_valid    in   upstream pixel valid
//   s_ready    out  block can accept a pixel this cycle
//   s_data     in   RGB565 pixel {r[4:0], g[5:0], b[4:0]}
//   s_sof      in   s_data is the first pixel of a frame
//   pix_en     in   one-clk strobe per LCD pixel clock
//   de         in   active video from the timing generator
//   vsync      in   low during vertical blanking
//   red/green/blue out  8-bit pixel to panel, 2 clk after pix_en
//   underrun   out  sticky: a line started with its bank empty
//   sync_err   out  sticky: s_sof accepted in the middle of a line
// -----------------------------------------------------------------------------
module lcd_line_buffer
    import lcd_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int ADDR_W   = ADDR_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [PIX_W-1:0] s_data,
    input  logic             s_sof,
    input  logic             pix_en,
    input  logic             de,
    input  logic             vsync,
    output logic [7:0]       red,
    output logic [7:0]       green,
    output logic [7:0]       blue,
    output logic             underrun,
    output logic             sync_err
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_ACTIVE - 1);
    localparam logic [ADDR_W-1:0] ONE_ADDR  = ADDR_W'(1);

    // Shared bank bookkeeping
    logic [1:0]        full;
    logic [1:0]        full_set;
    logic [1:0]        full_clr;

    // Write side
    wr_state_t         wr_state;
    wr_state_t         wr_state_nxt;
    logic              wr_bank;
    logic              wr_bank_nxt;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] wr_addr_nxt;
    logic [ADDR_W-1:0] wr_ptr;
    logic              wr_en;
    logic              accept;
    logic              sync_err_set;

    // Read side
    logic              rd_bank;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              rd_en;
    logic              rd_last;
    logic              playing;
    logic              de_last;
    logic              line_start;
    logic              de_fall;
    logic              underrun_set;

    // Output pipeline
    logic              upd_p1;
    logic              vld_p1;
    logic [PIX_W-1:0]  ram_rdata_p1;
    rgb888_t           rgb_p2;

    // -------------------------------------------------------------------------
    // Write FSM
    // -------------------------------------------------------------------------
    // s_ready is forced low while reset is asserted so nothing is handshaken
    // during the reset cycle; otherwise it depends only on registered state.
    always_comb begin
        s_ready = 1'b0;
        if (rst_n) begin
            if (wr_state == W_WAIT_SOF) begin
                s_ready = 1'b1;
            end else begin
                s_ready = !full[wr_bank];
            end
        end
    end

    assign accept = s_valid && s_ready;

    always_comb begin
        wr_state_nxt = wr_state;
        wr_bank_nxt  = wr_bank;
        wr_addr_nxt  = wr_addr;
        wr_ptr       = wr_addr;
        wr_en        = 1'b0;
        full_set     = 2'b00;
        sync_err_set = 1'b0;
        case (wr_state)
            W_WAIT_SOF: begin
                // Pixels ahead of the first frame start are swallowed.
                if (accept && s_sof) begin
                    wr_en        = 1'b1;
                    wr_ptr       = '0;
                    wr_addr_nxt  = ONE_ADDR;
                    wr_state_nxt = W_FILL;
                end
            end
            W_FILL: begin
                if (accept) begin
                    wr_en = 1'b1;
                    if (s_sof) begin
                        // Frame start realigns the current line in place; it
                        // is only an error if the line was partly written.
                        wr_ptr       = '0;
                        wr_addr_nxt  = ONE_ADDR;
                        sync_err_set = (wr_addr != '0);
                    end else if (wr_addr == LAST_ADDR) begin
                        full_set[wr_bank] = 1'b1;
                        wr_bank_nxt       = !wr_bank;
                        wr_addr_nxt       = '0;
                    end else begin
                        wr_addr_nxt = wr_addr + ONE_ADDR;
                    end
                end
            end
            default: begin
                wr_state_nxt = W_WAIT_SOF;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_state <= W_WAIT_SOF;
            wr_bank  <= 1'b0;
            wr_addr  <= '0;
        end else begin
            wr_state <= wr_state_nxt;
            wr_bank  <= wr_bank_nxt;
            wr_addr  <= wr_addr_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Read control (stage p0: pix_en cycle, address issued to the RAM)
    // -------------------------------------------------------------------------
    // Line boundaries are judged from de as seen on successive pix_en strobes.
    // Nothing on the read side moves while vsync is low.
    always_comb begin
        line_start   = pix_en && vsync && de && !de_last;
        de_fall      = pix_en && vsync && !de && de_last;
        rd_en        = 1'b0;
        rd_ptr       = rd_addr;
        underrun_set = 1'b0;
        if (line_start) begin
            rd_ptr = '0;
            if (full[rd_bank]) begin
                rd_en = 1'b1;
            end else begin
                underrun_set = 1'b1;
            end
        end else if (pix_en && vsync && de && playing) begin
            rd_en = 1'b1;
        end
        rd_last  = rd_en && (rd_ptr == LAST_ADDR);
        full_clr = 2'b00;
        // A short line (de drops early) frees its bank just like a full one.
        if (rd_last || (de_fall && playing)) begin
            full_clr[rd_bank] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_bank <= 1'b0;
            rd_addr <= '0;
            playing <= 1'b0;
            // Start as if inside de so a line already in progress when reset
            // drops is not mistaken for a fresh line start.
            de_last <= 1'b1;
        end else begin
            if (pix_en) begin
                de_last <= de;
            end
            if (full_clr != 2'b00) begin
                rd_bank <= !rd_bank;
                rd_addr <= '0;
            end else if (rd_en) begin
                rd_addr <= rd_ptr + ONE_ADDR;
            end
            if (line_start) begin
                playing <= full[rd_bank] && !rd_last;
            end else if (rd_last || de_fall) begin
                playing <= 1'b0;
            end
        end
    end

    // Writer only ever sets a non-full bank and reader only clears the bank
    // it is playing, so the two never target the same flag in one cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full     <= 2'b00;
            underrun <= 1'b0;
            sync_err <= 1'b0;
        end else begin
            full     <= (full | full_set) & ~full_clr;
            underrun <= underrun | underrun_set;
            sync_err <= sync_err | sync_err_set;
        end
    end

    lcd_line_ram #(
        .DATA_W (PIX_W),
        .ADDR_W (ADDR_W + 1)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr ({wr_bank, wr_ptr}),
        .wdata (s_data),
        .re    (rd_en),
        .raddr ({rd_bank, rd_ptr}),
        .rdata (ram_rdata_p1)
    );

    // -------------------------------------------------------------------------
    // Stage p1: RAM data available, strobe/valid delayed alongside
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            upd_p1 <= 1'b0;
            vld_p1 <= 1'b0;
        end else begin
            upd_p1 <= pix_en;
            vld_p1 <= rd_en;
        end
    end

    // -------------------------------------------------------------------------
    // Stage p2: output register, updated once per pixel strobe
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rgb_p2 <= '0;
        end else if (upd_p1) begin
            rgb_p2 <= vld_p1 ? rgb565_to_888(ram_rdata_p1) : '0;
        end
    end

    assign red   = rgb_p2.red;
    assign green = rgb_p2.green;
    assign blue  = rgb_p2.blue;

endmodule

// File: doc/lcd_line_buffer.md
# lcd_line_buffer

Ping-pong line buffer between an upstream RGB565 pixel producer (SD/SPI loader, DMA) and the LCD RGB timing generator. Accepts raster-order pixels on a valid/ready stream and stores one full line per bank. Plays each line out on the timing generator's pixel-advance strobe as 8-bit-per-channel RGB, replacing the test-pattern source. Flags underruns and frame-sync errors.

## Interface
- H_ACTIVE, 480, active pixels per line (reads and writes per bank)
- ADDR_W, 9, bank address width; must satisfy 2^ADDR_W ≥ H_ACTIVE

- clk  in  1  system clock (27 MHz)
- rst_n  in  1  reset, synchronous, active-low
- s_valid  in  1  upstream pixel valid
- s_ready  out  1  block can accept pixel
- s_data  in  16  RGB565 pixel {r[4:0], g[5:0], b[4:0]}
- s_sof  in  1  qualifies s_data as first pixel of a frame
- pix_en  in  1  one-clk strobe per LCD pixel clock (timing generator counter advance)
- de  in  1  active video from timing generator
- vsync  in  1  low during vertical blanking
- red, green, blue  out  8 each  pixel to panel
- underrun  out  1  sticky: line started with empty bank
- sync_err  out  1  sticky: s_sof arrived mid-line

## Operation
- Two banks (0/1), H_ACTIVE × 16 bits each; per-bank flag full[b]. Write pointer wr_bank/wr_addr, read pointer rd_bank/rd_addr.
- Write FSM:
  - W_WAIT_SOF: s_ready=1; non-sof pixels dropped. Accepted s_sof pixel → written at wr_addr 0, → W_FILL.
  - W_FILL: s_ready = !full[wr_bank]. Accepted pixel written at wr_addr, wr_addr++. Write of address H_ACTIVE-1 sets full[wr_bank], toggles wr_bank, wr_addr=0.
  - s_sof accepted in W_FILL with wr_addr≠0: set sync_err, restart line (write at 0, wr_addr=1), same bank. s_sof at wr_addr=0: normal.
- Read side:
  - Line start = first pix_en with de=1 after a pix_en with de=0. If full[rd_bank]: play bank. Else: set underrun, output black for the entire line, pointers unchanged.
  - Playing: each pix_en with de=1 reads rd_addr, rd_addr++. After H_ACTIVE reads: clear full[rd_bank], toggle rd_bank, rd_addr=0.
  - de falling before H_ACTIVE reads: bank released as if complete (extra/short timing tolerated).
  - vsync=0: no reads, no bank release.
- Expansion: red={r,r[4:2]}, green={g,g[5:4]}, blue={b,b[4:2]}. RGB = 0 whenever the displayed pixel was outside de or in an underrun line.
- Same-cycle set of full[x] (writer) and clear of full[y] (reader) both take effect; x=y impossible because writer is stalled on full.

## Timing
- Reset: s_ready=0 during reset cycle, then 1 (W_WAIT_SOF); red/green/blue=0; underrun=0; sync_err=0; full=00; pointers 0.
- Write: pixel accepted on cycle with s_valid&s_ready; s_ready combinational from registered state; zero-bubble sustained writes.
- Read latency: address issued on pix_en cycle, RAM sync read +1, output register +1 → RGB valid 2 clk after pix_en, held until next update.
- pix_en spacing must be ≥3 clk (design: 4 clk).
- Sticky flags clear only on reset.
- Reset mid-line: all state discarded; bank contents irrelevant (full=00).

## Structure
- Package lcd_pkg: H_ACTIVE default, RGB565→RGB888 expansion function, write-FSM state enum.
- Sub-module lcd_line_ram: simple dual-port RAM, depth 2·2^ADDR_W, 16 bit, sync read, bank as address MSB; infers Gowin BSRAM.

## Test plan
- Reset, stream s_sof + 479 pixels of 0xF800 with de off → full=01, s_ready=1; one de line → red=0xFF, green=0, blue=0 for 480 pix_en, 2 clk latency, full→00.
- Stream 3 lines with no reads → s_ready drops after 960th pixel, stays 0 until first line played.
- de line with no data loaded → underrun=1, RGB=0 whole line, pointers unchanged.
- s_sof at wr_addr=100 → sync_err=1, line restarts; following line displays only post-sof pixels.
- Pixels before any s_sof dropped (s_ready=1, full stays 00); 0x07E0 → green=0xFF; 0x001F → blue=0xFF.
- Assert rst_n=0 mid-line play → next cycle RGB=0, full=00, s_ready=1.
